// File: rtl/au_pkg.sv
// Shared types and constants for the I2S frame receiver.
package au_pkg;
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    localparam int   DEF_DATA_W = 24;
    localparam logic WS_LEFT    = 1'b0;
    localparam logic WS_RIGHT   = 1'b1;
endpackage

// File: rtl/au_sync_edge.sv
// Multi-flop synchroniser with a one-cycle rising-edge pulse on the synced level.
module au_sync_edge
    import au_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;
endmodule

// File: rtl/i2s_frame_rx.sv
// I2S receiver: oversamples bclk/ws/sdata in sys_clk and emits aligned L/R pairs.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing instead of one-bclk-delay I2S.
module i2s_frame_rx
    import au_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     bclk,
    input  logic                     ws,
    input  logic                     sdata,
    output logic                     receive_valid,
    output logic signed [DATA_W-1:0] receive_left_data,
    output logic signed [DATA_W-1:0] receive_right_data,
    output logic                     frame_err
);
    localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic bclk_lvl_unused, bclk_rise;
    logic ws_s, ws_rise_unused;
    logic sd_s, sd_rise_unused;

    au_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(sys_clk), .rst(sys_rst), .d(bclk), .q(bclk_lvl_unused), .rise(bclk_rise)
    );
    au_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(sys_clk), .rst(sys_rst), .d(ws), .q(ws_s), .rise(ws_rise_unused)
    );
    au_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(sys_clk), .rst(sys_rst), .d(sdata), .q(sd_s), .rise(sd_rise_unused)
    );

    rx_state_t         state, state_nx;
    logic              ws_cur;
    logic [DATA_W-1:0] shifter, shift_in, close_word, aligned;
    logic [DATA_W-1:0] left_hold, right_hold;
    logic [CNT_W-1:0]  bit_cnt, cnt_inc, close_cnt;
    logic              word_end, short_word, pair_done;
    logic              ld_left, ld_right, seq_err;

    // Left-align a word of n received bits; short words get zero LSBs.
    function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] w,
                                                input logic [CNT_W-1:0]  n);
        if (n >= DATA_W_C) return w;
        return w << (DATA_W_C - n);
    endfunction

    // ws_cur is the channel of the word in progress; a change on this edge ends it.
    assign word_end = bclk_rise && (ws_s != ws_cur);
    assign shift_in = (bit_cnt < DATA_W_C) ? {shifter[DATA_W-2:0], sd_s} : shifter;
    assign cnt_inc  = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;

`ifdef I2S_LEFT_JUSTIFIED_EN
    // The ws-change bit belongs to the next word, so close on what is already held.
    assign close_word = shifter;
    assign close_cnt  = bit_cnt;
`else
    // The ws-change bit is the LSB of the finishing word.
    assign close_word = shift_in;
    assign close_cnt  = cnt_inc;
`endif

    assign aligned    = align(close_word, close_cnt);
    assign short_word = close_cnt < DATA_W_C;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) state <= SYNC;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (word_end) begin
            case (state)
                SYNC:    if (ws_cur == WS_RIGHT) state_nx = LEFT;
                LEFT:    state_nx = (ws_cur == WS_LEFT)  ? RIGHT : SYNC;
                RIGHT:   state_nx = (ws_cur == WS_RIGHT) ? LEFT  : SYNC;
                default: state_nx = SYNC;
            endcase
        end
    end

    always_comb begin
        ld_left  = 1'b0;
        ld_right = 1'b0;
        seq_err  = 1'b0;
        if (word_end) begin
            ld_left  = (state == LEFT)  && (ws_cur == WS_LEFT);
            ld_right = (state == RIGHT) && (ws_cur == WS_RIGHT);
            seq_err  = (state != SYNC) && !ld_left && !ld_right;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            ws_cur             <= 1'b0;
            shifter            <= '0;
            bit_cnt            <= '0;
            left_hold          <= '0;
            right_hold         <= '0;
            pair_done          <= 1'b0;
            receive_valid      <= 1'b0;
            receive_left_data  <= '0;
            receive_right_data <= '0;
            frame_err          <= 1'b0;
        end else begin
            if (bclk_rise) begin
                ws_cur <= ws_s;
                if (word_end) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
                    shifter <= {{(DATA_W-1){1'b0}}, sd_s};
                    bit_cnt <= CNT_W'(1);
`else
                    shifter <= '0;
                    bit_cnt <= '0;
`endif
                end else begin
                    shifter <= shift_in;
                    bit_cnt <= cnt_inc;
                end
            end
            if (ld_left)  left_hold  <= aligned;
            if (ld_right) right_hold <= aligned;
            if ((word_end && short_word) || seq_err) frame_err <= 1'b1;

            // Publish the pair one cycle after the right word lands so both move together.
            pair_done     <= ld_right;
            receive_valid <= pair_done;
            if (pair_done) begin
                receive_left_data  <= left_hold;
                receive_right_data <= right_hold;
            end
        end
    end
endmodule

// File: tb/tb_i2s_frame_rx.sv
// Randomised bench for i2s_frame_rx against a bit-queue reference decoder.
module tb_i2s_frame_rx;
    localparam int DATA_W      = 24;
    localparam int SYNC_STAGES = 2;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam bit LJ_MODE = 1'b1;
`else
    localparam bit LJ_MODE = 1'b0;
`endif

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              bclk = 1'b0, ws = 1'b0, sdata = 1'b0;
    logic              receive_valid, frame_err;
    logic [DATA_W-1:0] rl, rr;

    i2s_frame_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .CNT_W(6)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bclk(bclk), .ws(ws), .sdata(sdata),
        .receive_valid(receive_valid), .receive_left_data(rl),
        .receive_right_data(rr), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, last_rise = 0, n_valid = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic tb_chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decoder: words are runs between ws changes, held as bit queues.
    logic [DATA_W-1:0] exp_l_q[$], exp_r_q[$];
    int                m_state;   // 0 hunting, 1 expect left, 2 expect right
    bit                m_ws, m_err;
    bit                m_bits[$];
    logic [DATA_W-1:0] m_lhold, m_last_l, m_last_r;
    int                m_nvalid = 0;

    task automatic m_reset();
        m_state = 0; m_ws = 1'b0; m_err = 1'b0; m_bits.delete();
        m_lhold = '0; m_last_l = '0; m_last_r = '0;
        exp_l_q.delete(); exp_r_q.delete();
    endtask

    task automatic m_close(input bit ch);
        logic [DATA_W-1:0] v;
        int n;
        v = '0;
        n = m_bits.size();
        for (int i = 0; i < DATA_W; i++) v[DATA_W-1-i] = (i < n) ? m_bits[i] : 1'b0;
        if (n < DATA_W) m_err = 1'b1;
        case (m_state)
            0: if (ch) m_state = 1;
            1: if (!ch) begin m_lhold = v; m_state = 2; end
               else begin m_state = 0; m_err = 1'b1; end
            default: if (ch) begin
                   exp_l_q.push_back(m_lhold); exp_r_q.push_back(v);
                   m_last_l = m_lhold; m_last_r = v; m_nvalid++; m_state = 1;
               end else begin m_state = 0; m_err = 1'b1; end
        endcase
        m_bits.delete();
    endtask

    task automatic m_slot(input bit w, input bit d);
        bit changed;
        changed = (w != m_ws);
        if (LJ_MODE) begin
            if (changed) m_close(m_ws);
            m_bits.push_back(d);
        end else begin
            m_bits.push_back(d);
            if (changed) m_close(m_ws);
        end
        m_ws = w;
    endtask

    // Stream under construction, in left-justified form (ws aligned with the MSB).
    bit sw[$], sdq[$];

    task automatic add_word(input bit ch, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin sw.push_back(ch); sdq.push_back(v[n-1-i]); end
    endtask

    task automatic add_frame(input int n, input logic [31:0] l, input logic [31:0] r);
        add_word(1'b0, n, l);
        add_word(1'b1, n, r);
    endtask

    function automatic logic [31:0] w32(input logic [23:0] v);
        return {v, 8'($urandom)};
    endfunction

    // Monitor: every pulse matches the model, is one cycle wide, and has fixed latency.
    logic              prev_vld = 1'b0;
    logic [DATA_W-1:0] prev_l = '0, prev_r = '0;
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            prev_l = '0; prev_r = '0;
        end else if (receive_valid) begin
            n_valid++;
            tb_chk("vld_width", prev_vld, 0);
            tb_chk("latency", cyc - last_rise, SYNC_STAGES + 2);
            if (exp_l_q.size() == 0) tb_chk("vld_unexp", receive_valid, 0);
            else begin
                tb_chk("left", rl, exp_l_q.pop_front());
                tb_chk("right", rr, exp_r_q.pop_front());
            end
            prev_l = rl; prev_r = rr;
        end else begin
            tb_chk("hold_l", rl, prev_l);
            tb_chk("hold_r", rr, prev_r);
        end
        prev_vld = receive_valid;
    end

    task automatic do_reset();
        bclk = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_reset();
        @(negedge sys_clk);
        tb_chk("rst_vld", receive_valid, 0);
        tb_chk("rst_l", rl, 0);
        tb_chk("rst_r", rr, 0);
        tb_chk("rst_err", frame_err, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic drive_slot(input bit w, input bit d, input int half);
        bclk = 1'b0; ws = w; sdata = d;
        repeat (half) @(negedge sys_clk);
        bclk = 1'b1; last_rise = cyc;
        repeat (half) @(negedge sys_clk);
    endtask

    // lj=0 moves each ws change one slot ahead of the MSB (I2S framing on the pins).
    task automatic play(input bit lj, input int half, input int rst_at);
        bit w;
        for (int t = 0; t < sw.size(); t++) begin
            w = (lj || t + 1 >= sw.size()) ? sw[t] : sw[t+1];
            if (t == rst_at) do_reset();
            m_slot(w, sdq[t]);
            drive_slot(w, sdq[t], half);
        end
        sw.delete(); sdq.delete();
    endtask

    task automatic settle(input string tag);
        repeat (20) @(negedge sys_clk);
        tb_chk({tag, "_pending"}, exp_l_q.size(), 0);
        tb_chk({tag, "_err"}, frame_err, m_err);
        tb_chk({tag, "_nvalid"}, n_valid, m_nvalid);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, nb, hp;
        repeat (3) @(negedge sys_clk);
        do_reset();

        // Three 32-bit-slot frames; the first is only used to lock onto the framing.
        v0 = n_valid;
        add_frame(32, $urandom, $urandom);
        add_frame(32, w32(24'h123456), w32(24'hABCDEF));
        add_frame(32, w32(24'h123456), w32(24'hABCDEF));
        add_word(1'b0, 2, 32'h0);
        play(LJ_MODE, 4, -1);
        settle("t1");
        tb_chk("t1_l", rl, 24'h123456);
        tb_chk("t1_r", rr, 24'hABCDEF);
        tb_chk("t1_err", frame_err, 0);
        tb_chk("t1_count", n_valid - v0, 2);

        // 16-bit words are padded low and flag a framing error.
        do_reset();
        v0 = n_valid;
        add_frame(16, $urandom, $urandom);
        add_frame(16, 32'h8001, $urandom);
        add_word(1'b0, 2, 32'h0);
        play(LJ_MODE, 3, -1);
        settle("t2");
        tb_chk("t2_l", rl, 24'h800100);
        tb_chk("t2_err", frame_err, 1);
        tb_chk("t2_count", n_valid - v0, 1);

        // Full-scale extremes at 64 bclk per frame.
        do_reset();
        v0 = n_valid;
        add_frame(32, $urandom, $urandom);
        add_frame(32, w32(24'h7FFFFF), w32(24'h800000));
        add_frame(32, w32(24'h7FFFFF), w32(24'h800000));
        add_word(1'b0, 2, 32'h0);
        play(LJ_MODE, 5, -1);
        settle("t3");
        tb_chk("t3_l", rl, 24'h7FFFFF);
        tb_chk("t3_r", rr, 24'h800000);
        tb_chk("t3_count", n_valid - v0, 2);

        // Random frames, then ws parked for 200 bclk, then normal traffic again.
        do_reset();
        hp = $urandom_range(3, 6);
        for (int f = 0; f < 5; f++) begin
            int n;
            n = ($urandom_range(0, 1) == 1) ? 32 : 24;
            add_frame(n, $urandom, $urandom);
        end
        for (int i = 0; i < 8; i++) add_word(1'b0, 1, $urandom);
        play(LJ_MODE, hp, -1);
        repeat (20) @(negedge sys_clk);
        nb = n_valid;
        for (int i = 0; i < 200; i++) add_word(1'b0, 1, $urandom);
        play(LJ_MODE, hp, -1);
        repeat (20) @(negedge sys_clk);
        tb_chk("t4_novalid", n_valid - nb, 0);
        tb_chk("t4_hold_l", rl, m_last_l);
        tb_chk("t4_hold_r", rr, m_last_r);
        add_word(1'b1, 32, $urandom);
        add_frame(32, $urandom, $urandom);
        add_word(1'b0, 2, 32'h0);
        play(LJ_MODE, hp, -1);
        settle("t4");

        // Reset ten bits into a left word; the broken frame must not surface.
        do_reset();
        v0 = n_valid;
        add_frame(32, $urandom, $urandom);
        add_frame(32, $urandom, $urandom);
        add_frame(32, $urandom, $urandom);
        add_frame(32, $urandom, $urandom);
        add_frame(32, $urandom, $urandom);
        add_word(1'b0, 2, 32'h0);
        play(LJ_MODE, 4, 2 * 64 + 10);
        settle("t5");
        tb_chk("t5_count", n_valid - v0, 3);
        tb_chk("t5_err", frame_err, 1);

        // Left-justified stimulus: only the left-justified build recovers it exactly.
        do_reset();
        add_frame(24, $urandom, $urandom);
        add_frame(24, 32'h0F0F0F, 32'h800000);
        add_frame(24, 32'h0F0F0F, 32'h800000);
        add_word(1'b0, 2, 32'h0);
        play(1'b1, 3, -1);
        settle("t6");
`ifdef I2S_LEFT_JUSTIFIED_EN
        tb_chk("t6_lj_l", rl, 24'h0F0F0F);
`else
        tb_chk("t6_i2s_l", rl, 24'h1E1E1F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
